// File: rtl/arf132b192e1r1w0cbbehcaa4acw_bcam_mbist_pkg.sv
// BCAM MBIST sequencer: shared state encoding and check-pipe entry layout.
package arf132b192e1r1w0cbbehcaa4acw_bcam_mbist_pkg;

    localparam int CM_LAT_MAX = 7;
    localparam int BIT_IDX_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        CMP_ALL,
        CMP_MSK,
        ROT,
        DRAIN,
        DONE
    } seq_state_t;

    typedef struct packed {
        logic                 valid;
        logic                 exp_ones;
        logic                 phase;
        logic                 all;
        logic [BIT_IDX_W-1:0] bit_idx;
    } pipe_ent_t;

endpackage

// File: rtl/arf132b192e1r1w0cbbehcaa4acw_bcam_mbist_seq_chkpipe.sv
// Expectation delay line aligned to the CAM latency, hit compare,
// and sticky fail flag with first-failure capture.
module arf132b192e1r1w0cbbehcaa4acw_bcam_mbist_seq_chkpipe
    import arf132b192e1r1w0cbbehcaa4acw_bcam_mbist_pkg::*;
#(
    parameter int DEPTH  = 192,
    parameter int CM_LAT = 2,
    parameter int BW     = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             ent_valid_i,
    input  logic             ent_ones_i,
    input  logic             ent_phase_i,
    input  logic             ent_all_i,
    input  logic [BW-1:0]    ent_bit_i,
    input  logic [DEPTH-1:0] hit_i,
    output logic             fail_o,
    output logic             fail_phase_o,
    output logic             fail_all_o,
    output logic [BW-1:0]    fail_bit_o
);

    pipe_ent_t     pipe_q [CM_LAT];
    pipe_ent_t     ent_in;
    pipe_ent_t     ent_out;
    logic          mism;
    logic          fail_q;
    logic          fail_phase_q;
    logic          fail_all_q;
    logic [BW-1:0] fail_bit_q;

    always_comb begin
        ent_in          = '0;
        ent_in.valid    = ent_valid_i;
        ent_in.exp_ones = ent_ones_i;
        ent_in.phase    = ent_phase_i;
        ent_in.all      = ent_all_i;
        ent_in.bit_idx  = BIT_IDX_W'(ent_bit_i);
    end

    assign ent_out = pipe_q[CM_LAT-1];
    assign mism    = ent_out.valid && (hit_i != {DEPTH{ent_out.exp_ones}});

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            for (int i = 0; i < CM_LAT; i++) pipe_q[i] <= '0;
            fail_q       <= 1'b0;
            fail_phase_q <= 1'b0;
            fail_all_q   <= 1'b0;
            fail_bit_q   <= '0;
        end else begin
            pipe_q[0] <= ent_in;
            for (int i = 1; i < CM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
            if (mism) begin
                fail_q <= 1'b1;
                // only the first mismatch of a run is recorded
                if (!fail_q) begin
                    fail_phase_q <= ent_out.phase;
                    fail_all_q   <= ent_out.all;
                    fail_bit_q   <= ent_out.bit_idx[BW-1:0];
                end
            end
        end
    end

    assign fail_o       = fail_q;
    assign fail_phase_o = fail_phase_q;
    assign fail_all_o   = fail_all_q;
    assign fail_bit_o   = fail_bit_q;

endmodule

// File: rtl/arf132b192e1r1w0cbbehcaa4acw_bcam_mbist_seq.sv
// BCAM MBIST sequencer: fills the array, then runs an unmasked and
// RF_DWIDTH single-bit-flipped compares per data phase.
module arf132b192e1r1w0cbbehcaa4acw_bcam_mbist_seq
    import arf132b192e1r1w0cbbehcaa4acw_bcam_mbist_pkg::*;
#(
    parameter int                   RF_DWIDTH  = 132,
    parameter int                   DEPTH      = 192,
    parameter int                   CM_LAT     = 2,
    parameter logic [RF_DWIDTH-1:0] BG_PATTERN = '0
) (
    input  logic                         bist_clk,
    input  logic                         rst,
    input  logic                         bist_start,
    output logic                         bist_busy,
    output logic                         bist_done,
    output logic                         bist_fail,
    output logic                         fail_phase,
    output logic                         fail_all,
    output logic [$clog2(RF_DWIDTH)-1:0] fail_bit,
    output logic                         wr_en,
    output logic [$clog2(DEPTH)-1:0]     wr_addr,
    output logic [RF_DWIDTH-1:0]         bist_wr_data,
    output logic                         bist_cm_mode,
    output logic                         bist_rotate_mask,
    output logic                         bist_cd_mask_enable,
    output logic                         bist_data_inv,
    output logic                         cm_en,
    input  logic [DEPTH-1:0]             cm_hit
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(RF_DWIDTH);

    seq_state_t    state_q;
    logic          busy_q;
    logic          done_q;
    logic          phase_q;
    logic          wr_en_q;
    logic          cm_en_q;
    logic          rot_q;
    logic          cd_q;
    logic [AW-1:0] wr_addr_q;
    logic [BW-1:0] bit_cnt_q;
    logic [2:0]    drn_q;
    logic          start_acc;

    assign start_acc = bist_start && (state_q == IDLE || state_q == DONE);

    always_ff @(posedge bist_clk) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            phase_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            cm_en_q   <= 1'b0;
            rot_q     <= 1'b0;
            cd_q      <= 1'b0;
            wr_addr_q <= '0;
            bit_cnt_q <= '0;
            drn_q     <= '0;
        end else begin
            wr_en_q <= 1'b0;
            cm_en_q <= 1'b0;
            rot_q   <= 1'b0;
            cd_q    <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (bist_start) begin
                        state_q   <= WRITE;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        phase_q   <= 1'b0;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= '0;
                        bit_cnt_q <= '0;
                    end
                end
                WRITE: begin
                    if (wr_addr_q == AW'(DEPTH - 1)) begin
                        state_q   <= CMP_ALL;
                        wr_addr_q <= '0;
                        cm_en_q   <= 1'b1;
                    end else begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= wr_addr_q + 1'b1;
                    end
                end
                CMP_ALL: begin
                    state_q <= CMP_MSK;
                    cm_en_q <= 1'b1;
                    cd_q    <= 1'b1;
                end
                CMP_MSK: begin
                    state_q <= ROT;
                    rot_q   <= 1'b1;
                end
                ROT: begin
                    // wrapping here leaves the mask at bit 0 for the next phase
                    if (bit_cnt_q == BW'(RF_DWIDTH - 1)) begin
                        bit_cnt_q <= '0;
                        state_q   <= DRAIN;
                        drn_q     <= '0;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        state_q   <= CMP_MSK;
                        cm_en_q   <= 1'b1;
                        cd_q      <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (drn_q == 3'(CM_LAT - 1)) begin
                        if (phase_q) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            phase_q <= 1'b0;
                        end else begin
                            state_q   <= WRITE;
                            phase_q   <= 1'b1;
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= '0;
                        end
                    end else begin
                        drn_q <= drn_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    arf132b192e1r1w0cbbehcaa4acw_bcam_mbist_seq_chkpipe #(
        .DEPTH  (DEPTH),
        .CM_LAT (CM_LAT),
        .BW     (BW)
    ) u_chk (
        .clk_i        (bist_clk),
        .rst_i        (rst),
        .clr_i        (start_acc),
        .ent_valid_i  (cm_en_q),
        .ent_ones_i   (~cd_q),
        .ent_phase_i  (phase_q),
        .ent_all_i    (~cd_q),
        .ent_bit_i    (bit_cnt_q),
        .hit_i        (cm_hit),
        .fail_o       (bist_fail),
        .fail_phase_o (fail_phase),
        .fail_all_o   (fail_all),
        .fail_bit_o   (fail_bit)
    );

    assign bist_busy           = busy_q;
    assign bist_done           = done_q;
    assign wr_en               = wr_en_q;
    assign wr_addr             = wr_addr_q;
    assign bist_wr_data        = BG_PATTERN;
    assign bist_cm_mode        = busy_q;
    assign bist_rotate_mask    = rot_q;
    assign bist_cd_mask_enable = cd_q;
    assign bist_data_inv       = phase_q;
    assign cm_en               = cm_en_q;

endmodule

// File: tb/tb_arf132b192e1r1w0cbbehcaa4acw_bcam_mbist_seq.sv
// Bench: ideal inhandler + CAM model with injectable faults, run-level
// scoreboard checked by an independent monitor.
module tb_arf132b192e1r1w0cbbehcaa4acw_bcam_mbist_seq;

    localparam int W    = 4;
    localparam int D    = 8;
    localparam int L    = 2;
    localparam int NCMP = 2 * (W + 1);
    localparam int RUN  = 2 * (D + 1 + 2 * W + L);

    logic         bist_clk;
    logic         rst;
    logic         bist_start;
    logic         bist_busy;
    logic         bist_done;
    logic         bist_fail;
    logic         fail_phase;
    logic         fail_all;
    logic [1:0]   fail_bit;
    logic         wr_en;
    logic [2:0]   wr_addr;
    logic [W-1:0] bist_wr_data;
    logic         bist_cm_mode;
    logic         bist_rotate_mask;
    logic         bist_cd_mask_enable;
    logic         bist_data_inv;
    logic         cm_en;
    logic [D-1:0] cm_hit;

    arf132b192e1r1w0cbbehcaa4acw_bcam_mbist_seq #(
        .RF_DWIDTH (W),
        .DEPTH     (D),
        .CM_LAT    (L)
    ) dut (
        .bist_clk            (bist_clk),
        .rst                 (rst),
        .bist_start          (bist_start),
        .bist_busy           (bist_busy),
        .bist_done           (bist_done),
        .bist_fail           (bist_fail),
        .fail_phase          (fail_phase),
        .fail_all            (fail_all),
        .fail_bit            (fail_bit),
        .wr_en               (wr_en),
        .wr_addr             (wr_addr),
        .bist_wr_data        (bist_wr_data),
        .bist_cm_mode        (bist_cm_mode),
        .bist_rotate_mask    (bist_rotate_mask),
        .bist_cd_mask_enable (bist_cd_mask_enable),
        .bist_data_inv       (bist_data_inv),
        .cm_en               (cm_en),
        .cm_hit              (cm_hit)
    );

    initial bist_clk = 1'b0;
    always #5 bist_clk = ~bist_clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // ---- environment: inhandler mask + CAM with fault hooks ----
    bit cell_en, flip_en;
    int cell_e, cell_b, cell_p, flip_k, flip_e;
    logic [W-1:0] mem [D];
    logic [D-1:0] hpipe [L];
    int mask_idx;
    int cmp_cnt;

    function automatic logic [D-1:0] cam_search();
        logic [W-1:0] key;
        logic [W-1:0] care;
        logic [D-1:0] h;
        key = bist_wr_data ^ {W{bist_data_inv}};
        if (bist_cd_mask_enable) key[mask_idx] = ~key[mask_idx];
        for (int e = 0; e < D; e++) begin
            care = '1;
            if (cell_en && e == cell_e && bist_data_inv == cell_p[0])
                care[cell_b] = 1'b0;
            h[e] = (((mem[e] ^ key) & care) == '0);
        end
        if (flip_en && cmp_cnt == flip_k) h[flip_e] = ~h[flip_e];
        return h;
    endfunction

    always @(posedge bist_clk) begin
        if (rst) begin
            mask_idx <= 0;
            cmp_cnt  <= 0;
            for (int i = 0; i < L; i++) hpipe[i] <= '0;
        end else begin
            if (bist_rotate_mask) mask_idx <= (mask_idx + 1) % W;
            if (!bist_busy) cmp_cnt <= 0;
            else if (cm_en) cmp_cnt <= cmp_cnt + 1;
            if (wr_en) mem[wr_addr] <= bist_wr_data ^ {W{bist_data_inv}};
            hpipe[0] <= cm_en ? cam_search() : D'($urandom);
            for (int i = 1; i < L; i++) hpipe[i] <= hpipe[i-1];
        end
    end
    assign cm_hit = hpipe[L-1];

    // ---- scoreboard ----
    typedef struct {
        bit fail;
        bit ph;
        bit all;
        int bitx;
    } exp_t;
    exp_t sb[$];

    task automatic run(input bit ce_en, input int ce, input int cb,
                       input int cp, input bit fk_en, input int fk,
                       input int fe, input bit extra);
        exp_t x;
        int first;
        bit seen;
        cell_en = ce_en; cell_e = ce; cell_b = cb; cell_p = cp;
        flip_en = fk_en; flip_k = fk; flip_e = fe;
        first = NCMP;
        if (ce_en) first = cp * (W + 1) + 1 + cb;
        if (fk_en && fk < first) first = fk;
        x.fail = (first < NCMP);
        x.ph   = x.fail ? (first / (W + 1) == 1) : 1'b0;
        x.all  = x.fail ? (first % (W + 1) == 0) : 1'b0;
        x.bitx = (x.fail && !x.all) ? first % (W + 1) - 1 : 0;
        sb.push_back(x);
        @(negedge bist_clk); bist_start = 1'b1;
        @(negedge bist_clk); bist_start = 1'b0;
        if (extra) begin
            repeat ($urandom_range(3, 30)) @(negedge bist_clk);
            bist_start = 1'b1;
            @(negedge bist_clk); bist_start = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bist_done) begin seen = 1'b1; break; end
            @(negedge bist_clk);
        end
        chk("done_timeout", seen, 1);
        repeat (2) @(negedge bist_clk);
    endtask

    // ---- monitor ----
    initial begin
        bit active;
        int nb, nw, sa, nc, nr, bad;
        exp_t e;
        active = 1'b0;
        nb = 0; nw = 0; sa = 0; nc = 0; nr = 0; bad = 0;
        forever begin
            @(negedge bist_clk);
            if (rst) begin
                active = 1'b0;
            end else if (bist_busy) begin
                if (!active) begin
                    active = 1'b1;
                    nb = 0; nw = 0; sa = 0; nc = 0; nr = 0; bad = 0;
                    chk("done_low_in_run", bist_done, 0);
                end
                nb++;
                if (wr_en) begin nw++; sa += wr_addr; end
                if (cm_en) nc++;
                if (bist_rotate_mask) nr++;
                if (bist_cm_mode !== 1'b1) bad++;
            end else if (active) begin
                active = 1'b0;
                chk("busy_cycles", nb, RUN);
                chk("wr_cycles", nw, 2 * D);
                chk("wr_addr_sum", sa, D * (D - 1));
                chk("compares", nc, NCMP);
                chk("rotates", nr, 2 * W);
                chk("cm_mode_busy", bad, 0);
                chk("done_set", bist_done, 1);
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("fail", bist_fail, e.fail);
                    chk("fail_phase", fail_phase, e.ph);
                    chk("fail_all", fail_all, e.all);
                    chk("fail_bit", fail_bit, e.bitx);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    // ---- stimulus ----
    initial begin
        int cnt;
        bit hit3;
        rst = 1'b1;
        bist_start = 1'b0;
        cell_en = 0; flip_en = 0;
        repeat (3) @(negedge bist_clk);
        chk("reset_outputs",
            {bist_busy, bist_done, bist_fail, fail_phase, fail_all,
             fail_bit, wr_en, wr_addr, bist_cm_mode, bist_rotate_mask,
             bist_cd_mask_enable, bist_data_inv, cm_en}, 0);
        chk("wr_data_bg", bist_wr_data, 0);
        rst = 1'b0;
        repeat (2) @(negedge bist_clk);

        run(0, 0, 0, 0, 0, 0, 0, 0);
        run(1, 3, 2, 0, 0, 0, 0, 0);
        run(1, 2, 1, 1, 1, 0, 5, 0);
        run(0, 0, 0, 0, 0, 0, 0, 1);

        // reset at the 3rd masked compare of phase 1
        cell_en = 0; flip_en = 0;
        @(negedge bist_clk); bist_start = 1'b1;
        @(negedge bist_clk); bist_start = 1'b0;
        cnt = 0; hit3 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (cm_en && bist_cd_mask_enable && bist_data_inv) cnt++;
            if (cnt == 3) begin hit3 = 1'b1; break; end
            @(negedge bist_clk);
        end
        chk("reach_3rd_cmp", hit3, 1);
        rst = 1'b1;
        @(negedge bist_clk);
        chk("midrun_rst_outputs",
            {bist_busy, bist_done, bist_fail, fail_phase, fail_all,
             fail_bit, wr_en, wr_addr, bist_cm_mode, bist_rotate_mask,
             bist_cd_mask_enable, bist_data_inv, cm_en}, 0);
        @(negedge bist_clk);
        rst = 1'b0;
        @(negedge bist_clk);
        run(0, 0, 0, 0, 0, 0, 0, 0);

        for (int r = 0; r < 12; r++) begin
            int kind, ce, cb, cp, fk, fe;
            kind = $urandom_range(0, 3);
            ce = $urandom_range(0, D - 1);
            cb = $urandom_range(0, W - 1);
            cp = $urandom_range(0, 1);
            fk = $urandom_range(0, NCMP - 1);
            fe = $urandom_range(0, D - 1);
            if (kind == 3 && fk == cp * (W + 1) + 1 + cb)
                fk = (fk + 1) % NCMP;
            run(kind[0], ce, cb, cp, kind[1], fk, fe, $urandom_range(0, 1) == 1);
        end

        repeat (5) @(negedge bist_clk);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
